// File: rtl/bitmap_dma.sv
// Bitmap drain DMA: waits for all plotter pixel engines to go idle, reads the 1-bpp bitmap
// byte by byte over the plotter slave port and writes packed 32-bit words to memory.
module bitmap_dma #(
  parameter int              DATAW       = 18,
  parameter int              CIRCLES     = 12,
  parameter logic [DATAW:0]  STATUS_ADDR = 19'h40000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             readdatavalid,
  output logic             waitrequest,
  output logic             cread,
  output logic [DATAW:0]   caddress,
  input  logic [31:0]      creaddata,
  input  logic             creaddatavalid,
  input  logic             cwaitrequest,
  output logic             mwrite,
  output logic [31:0]      maddress,
  output logic [31:0]      mwritedata,
  input  logic             mwaitrequest
);

  localparam int SRCW = DATAW - 3;
  localparam logic [SRCW-1:0] SRC_ONE = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL   = 3'd1,
    POLLW  = 3'd2,
    FETCH  = 3'd3,
    FETCHW = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t          state, next_state;
  logic [31:0]     dst_reg;
  logic [15:0]     len_reg;
  logic [SRCW-1:0] src_reg;
  logic            busy, done;
  logic [SRCW-1:0] src_ptr;
  logic [31:0]     dst_ptr;
  logic [15:0]     remaining;
  logic [31:0]     word;
  logic [1:0]      byte_idx;
  logic [31:0]     csr_rdata;
  logic            start;
  logic            unused_bits;

  // Configuration is frozen for the whole transfer: starts and CSR writes while busy are dropped.
  assign start        = write && (address == 2'd0) && writedata[0] && !busy;
  assign waitrequest  = 1'b0;
  assign maddress     = dst_ptr;
  assign mwritedata   = word;
  assign unused_bits  = ^creaddata[31:CIRCLES];

  always_comb begin
    csr_rdata = 32'd0;
    case (address)
      2'd0: csr_rdata = {30'd0, done, busy};
      2'd1: csr_rdata = dst_reg;
      2'd2: csr_rdata = {16'd0, len_reg};
      2'd3: csr_rdata = {{(32-SRCW){1'b0}}, src_reg};
      default: csr_rdata = 32'd0;
    endcase
  end

  // Strobes and the plotter address depend only on state, so every master request holds
  // steady across a stall.
  always_comb begin
    next_state = state;
    cread      = 1'b0;
    caddress   = '0;
    mwrite     = 1'b0;
    case (state)
      IDLE:   if (start && (len_reg != 16'd0)) next_state = POLL;
      POLL: begin
        cread    = 1'b1;
        caddress = STATUS_ADDR;
        if (!cwaitrequest) next_state = POLLW;
      end
      POLLW:  if (creaddatavalid) next_state = (&creaddata[CIRCLES-1:0]) ? FETCH : POLL;
      FETCH: begin
        cread    = 1'b1;
        caddress = {{(DATAW+1-SRCW){1'b0}}, src_ptr};
        if (!cwaitrequest) next_state = FETCHW;
      end
      FETCHW: if (creaddatavalid) next_state = (byte_idx == 2'd3) ? WRITE : FETCH;
      WRITE: begin
        mwrite = 1'b1;
        if (!mwaitrequest) next_state = (remaining == 16'd4) ? DONE : FETCH;
      end
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dst_reg       <= 32'd0;
      len_reg       <= 16'd0;
      src_reg       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      src_ptr       <= '0;
      dst_ptr       <= 32'd0;
      remaining     <= 16'd0;
      word          <= 32'd0;
      byte_idx      <= 2'd0;
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
    end else begin
      state         <= next_state;
      readdatavalid <= read;
      readdata      <= read ? csr_rdata : 32'd0;

      if (write && !busy) begin
        case (address)
          2'd1: dst_reg <= {writedata[31:2], 2'b00};
          2'd2: len_reg <= (writedata > 32'd32768) ? 16'h8000 : {writedata[15:2], 2'b00};
          2'd3: src_reg <= writedata[SRCW-1:0];
          default: ;
        endcase
      end

      if (start) begin
        if (len_reg == 16'd0) begin
          done <= 1'b1;
        end else begin
          busy      <= 1'b1;
          done      <= 1'b0;
          src_ptr   <= src_reg;
          dst_ptr   <= dst_reg;
          remaining <= len_reg;
          byte_idx  <= 2'd0;
        end
      end

      // Little-endian packing; src_ptr wraps naturally at the bitmap size.
      if (state == FETCHW && creaddatavalid) begin
        for (int k = 0; k < 4; k++) begin
          if (byte_idx == 2'(k)) word[8*k +: 8] <= creaddata[7:0];
        end
        src_ptr  <= src_ptr + SRC_ONE;
        byte_idx <= byte_idx + 2'd1;
      end

      if (state == WRITE && !mwaitrequest) begin
        dst_ptr   <= dst_ptr + 32'd4;
        remaining <= remaining - 16'd4;
      end

      if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
